// File: rtl/adc_dac_loop_mc.sv
// adc_dac_loop_mc: multi-channel ADC averaging with shared-multiplier gain/offset calibration into clamped DAC codes.
// Define ADC_DAC_LOOP_CONT_EN for back-to-back runs while ENABLE stays high.
module adc_dac_loop_mc #(
  parameter int NUM_CH      = 2,
  parameter int ADC_WIDTH   = 12,
  parameter int DAC_WIDTH   = 14,
  parameter int FLOAT_WIDTH = 64,
  parameter int LOG2_SAMPS  = 10
) (
  input  logic                          ADC_CLK,
  input  logic                          RST_N,
  input  logic                          ENABLE,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
  input  logic [NUM_CH*FLOAT_WIDTH-1:0] CAL_GAIN,
  input  logic [NUM_CH*FLOAT_WIDTH-1:0] CAL_OFFSET,
  output logic [NUM_CH*FLOAT_WIDTH-1:0] AVG_OUT,
  output logic [NUM_CH*DAC_WIDTH-1:0]   DAC_CODE_OUT,
  output logic [NUM_CH-1:0]             SAT_FLAG,
  output logic                          BUSY,
  output logic                          DONE
);

  localparam int ACC_W     = ADC_WIDTH + LOG2_SAMPS;
  localparam int FRAC_W    = 48;
  localparam int AVG_SHIFT = FRAC_W - LOG2_SAMPS;
  localparam int HI_W      = FLOAT_WIDTH - FRAC_W + 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]        LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [LOG2_SAMPS-1:0]  LAST_SAMP = '1;
  localparam logic [FLOAT_WIDTH-1:0] POS_MAX   = {1'b0, {(FLOAT_WIDTH-1){1'b1}}};
  localparam logic [FLOAT_WIDTH-1:0] NEG_MAX   = {1'b1, {(FLOAT_WIDTH-1){1'b0}}};
  localparam logic [15:0]            DAC_MAX   = 16'((32'd1 << DAC_WIDTH) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_CAL    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Q16.48 signed multiply: full product, arithmetic >>48, saturate to 64 bits. Returns {sat, value}.
  function automatic logic [FLOAT_WIDTH:0] mul_q48(input logic [FLOAT_WIDTH-1:0] a,
                                                   input logic [FLOAT_WIDTH-1:0] b);
    logic [2*FLOAT_WIDTH-1:0] prod;
    logic [HI_W-1:0]          hi;
    prod = {{FLOAT_WIDTH{a[FLOAT_WIDTH-1]}}, a} * {{FLOAT_WIDTH{b[FLOAT_WIDTH-1]}}, b};
    hi   = prod[2*FLOAT_WIDTH-1 -: HI_W];
    if (hi == {HI_W{prod[FLOAT_WIDTH+FRAC_W-1]}}) begin
      mul_q48 = {1'b0, prod[FRAC_W +: FLOAT_WIDTH]};
    end else begin
      mul_q48 = {1'b1, (prod[2*FLOAT_WIDTH-1] ? NEG_MAX : POS_MAX)};
    end
  endfunction

  // Signed saturating add. Returns {sat, value}.
  function automatic logic [FLOAT_WIDTH:0] add_sat(input logic [FLOAT_WIDTH-1:0] a,
                                                   input logic [FLOAT_WIDTH-1:0] b);
    logic [FLOAT_WIDTH:0] sum;
    sum = {a[FLOAT_WIDTH-1], a} + {b[FLOAT_WIDTH-1], b};
    if (sum[FLOAT_WIDTH] != sum[FLOAT_WIDTH-1]) begin
      add_sat = {1'b1, (sum[FLOAT_WIDTH] ? NEG_MAX : POS_MAX)};
    end else begin
      add_sat = {1'b0, sum[FLOAT_WIDTH-1:0]};
    end
  endfunction

  // Integer part (floor) clamped to the DAC range. Returns {clamped, code}.
  function automatic logic [DAC_WIDTH:0] dac_clamp(input logic [FLOAT_WIDTH-1:0] v);
    logic [15:0] int_part;
    int_part = {1'b0, v[FLOAT_WIDTH-2:FRAC_W]};
    if (v[FLOAT_WIDTH-1]) begin
      dac_clamp = {1'b1, {DAC_WIDTH{1'b0}}};
    end else if (int_part > DAC_MAX) begin
      dac_clamp = {1'b1, DAC_MAX[DAC_WIDTH-1:0]};
    end else begin
      dac_clamp = {1'b0, int_part[DAC_WIDTH-1:0]};
    end
  endfunction

  state_t                   state_r;
  logic                     enable_r;
  logic                     busy_r;
  logic                     done_r;
  logic [LOG2_SAMPS-1:0]    samp_cnt_r;
  logic [CH_W-1:0]          ch_idx_r;
  logic [ACC_W-1:0]         acc_r       [NUM_CH];
  logic [FLOAT_WIDTH-1:0]   stage_r     [NUM_CH];
  logic                     stage_sat_r [NUM_CH];
  logic [NUM_CH*FLOAT_WIDTH-1:0] avg_out_r;
  logic [NUM_CH*DAC_WIDTH-1:0]   dac_out_r;
  logic [NUM_CH-1:0]             sat_out_r;

  logic [ADC_WIDTH-1:0]     adc_s     [NUM_CH];
  logic [FLOAT_WIDTH-1:0]   gain_s    [NUM_CH];
  logic [FLOAT_WIDTH-1:0]   offset_s  [NUM_CH];
  logic [DAC_WIDTH:0]       dac_res_s [NUM_CH];
  logic [FLOAT_WIDTH-1:0]   avg_q_s;
  logic [FLOAT_WIDTH:0]     mul_res_s;
  logic [FLOAT_WIDTH:0]     add_res_s;

  // Unpack per-channel buses and precompute DAC clamp of each staged result.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      adc_s[c]     = ADC_DATA_IN[c*ADC_WIDTH +: ADC_WIDTH];
      gain_s[c]    = CAL_GAIN[c*FLOAT_WIDTH +: FLOAT_WIDTH];
      offset_s[c]  = CAL_OFFSET[c*FLOAT_WIDTH +: FLOAT_WIDTH];
      dac_res_s[c] = dac_clamp(stage_r[c]);
    end
  end

  // Shared calibration datapath for the channel selected by ch_idx_r; the average shift is exact.
  always_comb begin
    avg_q_s   = {{(FLOAT_WIDTH-ACC_W){acc_r[ch_idx_r][ACC_W-1]}}, acc_r[ch_idx_r]} << AVG_SHIFT;
    mul_res_s = mul_q48(avg_q_s, gain_s[ch_idx_r]);
    add_res_s = add_sat(mul_res_s[FLOAT_WIDTH-1:0], offset_s[ch_idx_r]);
  end

  // Run sequencer: ENABLE edge detect, accumulation, per-channel calibration, output update.
  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      enable_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      samp_cnt_r <= '0;
      ch_idx_r   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_r[c]       <= '0;
        stage_r[c]     <= '0;
        stage_sat_r[c] <= 1'b0;
      end
      avg_out_r  <= '0;
      dac_out_r  <= '0;
      sat_out_r  <= '0;
    end else begin
      enable_r <= ENABLE;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ENABLE && !enable_r) begin
            state_r    <= ST_ACCUM;
            busy_r     <= 1'b1;
            samp_cnt_r <= '0;
            ch_idx_r   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              acc_r[c] <= '0;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (!ENABLE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            for (int c = 0; c < NUM_CH; c++) begin
              acc_r[c] <= acc_r[c] + {{LOG2_SAMPS{adc_s[c][ADC_WIDTH-1]}}, adc_s[c]};
            end
            samp_cnt_r <= samp_cnt_r + 1'b1;
            if (samp_cnt_r == LAST_SAMP) begin
              state_r  <= ST_CAL;
              ch_idx_r <= '0;
            end
          end
        end
        ST_CAL: begin
          if (!ENABLE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            stage_r[ch_idx_r]     <= add_res_s[FLOAT_WIDTH-1:0];
            stage_sat_r[ch_idx_r] <= add_res_s[FLOAT_WIDTH] | mul_res_s[FLOAT_WIDTH];
            if (ch_idx_r == LAST_CH) begin
              state_r <= ST_FINISH;
              busy_r  <= 1'b0;
            end else begin
              ch_idx_r <= ch_idx_r + 1'b1;
            end
          end
        end
        ST_FINISH: begin
          for (int c = 0; c < NUM_CH; c++) begin
            avg_out_r[c*FLOAT_WIDTH +: FLOAT_WIDTH] <= stage_r[c];
            dac_out_r[c*DAC_WIDTH +: DAC_WIDTH]     <= dac_res_s[c][DAC_WIDTH-1:0];
            sat_out_r[c]                            <= stage_sat_r[c] | dac_res_s[c][DAC_WIDTH];
          end
          done_r <= 1'b1;
`ifdef ADC_DAC_LOOP_CONT_EN
          if (ENABLE) begin
            state_r    <= ST_ACCUM;
            busy_r     <= 1'b1;
            samp_cnt_r <= '0;
            ch_idx_r   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              acc_r[c] <= '0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
`else
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign AVG_OUT      = avg_out_r;
  assign DAC_CODE_OUT = dac_out_r;
  assign SAT_FLAG     = sat_out_r;
  assign BUSY         = busy_r;
  assign DONE         = done_r;

endmodule

// File: tb/tb_adc_dac_loop_mc.sv
// Scoreboard bench for adc_dac_loop_mc (NUM_CH=2, LOG2_SAMPS=2): directed runs, aborts, reset and held ENABLE.
module tb_adc_dac_loop_mc;

  localparam logic [63:0] ONE = 64'h0001_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [23:0]  adc;
  logic [127:0] gain;
  logic [127:0] offset;
  logic [127:0] avg_out;
  logic [27:0]  dac_out;
  logic [1:0]   sat;
  logic         busy;
  logic         done;

  typedef struct {
    logic [63:0] avg0;
    logic [63:0] avg1;
    logic [13:0] dac0;
    logic [13:0] dac1;
    logic [1:0]  sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  adc_dac_loop_mc #(
    .NUM_CH(2), .ADC_WIDTH(12), .DAC_WIDTH(14), .FLOAT_WIDTH(64), .LOG2_SAMPS(2)
  ) dut (
    .ADC_CLK(clk), .RST_N(rst_n), .ENABLE(enable), .ADC_DATA_IN(adc),
    .CAL_GAIN(gain), .CAL_OFFSET(offset), .AVG_OUT(avg_out), .DAC_CODE_OUT(dac_out),
    .SAT_FLAG(sat), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic push_exp(input logic [63:0] a0, input logic [63:0] a1, input logic [13:0] d0,
                          input logic [13:0] d1, input logic [1:0] s, input int c);
    exp_t e;
    e.avg0 = a0; e.avg1 = a1; e.dac0 = d0; e.dac1 = d1; e.sat = s; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every DONE pulse is matched against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got DONE=1 at cycle %0d expected no pending run", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("avg0", avg_out[63:0], e.avg0);
          chk("avg1", avg_out[127:64], e.avg1);
          chk("dac0", dac_out[13:0], e.dac0);
          chk("dac1", dac_out[27:14], e.dac1);
          chk("sat", sat, e.sat);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One full run: samples s0/s1 hold 4 x 12-bit values, sample 0 in the low bits.
  task automatic run(input logic [47:0] s0, input logic [47:0] s1,
                     input logic [63:0] g0, input logic [63:0] g1,
                     input logic [63:0] o0, input logic [63:0] o1,
                     input logic [63:0] a0, input logic [63:0] a1,
                     input logic [13:0] d0, input logic [13:0] d1, input logic [1:0] s);
    @(negedge clk);
    gain   = {g1, g0};
    offset = {o1, o0};
    adc    = {s1[11:0], s0[11:0]};
    enable = 1'b1;
    push_exp(a0, a1, d0, d1, s, cyc + 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      adc = {s1[i*12 +: 12], s0[i*12 +: 12]};
    end
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base;
    int n_exp_done;
    rst_n  = 1'b0;
    enable = 1'b0;
    adc    = 24'h000000;
    gain   = 128'h0;
    offset = 128'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("reset_avg", avg_out, 128'h0);
    chk("reset_dac", dac_out, 28'h0);
    chk("reset_sat", sat, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Plain average and fractional average plus offset.
    run({4{12'h064}}, {12'hFFD, 12'hFFC, 12'hFFC, 12'hFFC}, ONE, ONE, 64'h0, 64'h0008_0000_0000_0000,
        64'h0064_0000_0000_0000, 64'h0004_4000_0000_0000, 14'd100, 14'd4, 2'b00);
    // DAC clamp high and low.
    run({4{12'h3E8}}, {4{12'hFFB}}, 64'h0014_0000_0000_0000, ONE, 64'h0, 64'h0,
        64'h4E20_0000_0000_0000, 64'hFFFB_0000_0000_0000, 14'd16383, 14'd0, 2'b11);
    // Multiplier saturation on ch0, offset-add saturation on ch1.
    run({4{12'h7FF}}, {4{12'h7FF}}, 64'h7FFF_0000_0000_0000, 64'h0010_0000_0000_0000,
        64'h0, 64'h7FFF_0000_0000_0000,
        64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 14'd16383, 14'd16383, 2'b11);
    // Fractional gain, negative gain, negative offset; ch1 lands at 0.25 (code 0, no clamp).
    run({12'h00D, 12'h00C, 12'h00B, 12'h00A}, {12'h003, 12'h002, 12'h001, 12'h000},
        64'h0000_8000_0000_0000, 64'hFFFE_0000_0000_0000,
        64'hFFFF_0000_0000_0000, 64'h0003_4000_0000_0000,
        64'h0004_C000_0000_0000, 64'h0000_4000_0000_0000, 14'd4, 14'd0, 2'b00);

    // ENABLE held high for 20 cycles.
    @(negedge clk);
    adc    = {12'hFFC, 12'h064};
    gain   = {ONE, ONE};
    offset = 128'h0;
    enable = 1'b1;
    base   = done_cnt;
    push_exp(64'h0064_0000_0000_0000, 64'hFFFC_0000_0000_0000, 14'd100, 14'd0, 2'b10, cyc + 8);
`ifdef ADC_DAC_LOOP_CONT_EN
    push_exp(64'h0064_0000_0000_0000, 64'hFFFC_0000_0000_0000, 14'd100, 14'd0, 2'b10, cyc + 15);
    n_exp_done = 2;
`else
    n_exp_done = 1;
`endif
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_done_count", done_cnt - base, n_exp_done);

    // Abort: ENABLE low at t0+2.
    @(negedge clk);
    adc    = {12'h123, 12'h123};
    enable = 1'b1;
    @(negedge clk);
    chk("abort_busy_hi", busy, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy_lo", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_avg", avg_out, {64'hFFFC_0000_0000_0000, 64'h0064_0000_0000_0000});
    chk("abort_dac", dac_out, {14'd0, 14'd100});
    chk("abort_sat", sat, 2'b10);

    // Reset pulse in the middle of CAL.
    @(negedge clk);
    adc    = {12'h050, 12'h050};
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("midcal_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_avg", avg_out, 128'h0);
    chk("midrst_dac", dac_out, 28'h0);
    chk("midrst_sat", sat, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_avg", avg_out, 128'h0);
    chk("postrst_dac", dac_out, 28'h0);

    chk("pending_runs", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
